pipe_stage_buffer: RTL and testbench

- Parametrised, elastic pipeline-stage register for the MIPS datapath, successor to the fixed ID/EX latch.
- Carries a packed control bundle, NDATA data words and two register-address fields between stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush (bubble insertion with control zeroing), an occupancy report and a saturating stall counter.
- Instantiated between ID/EX, EX/MEM and MEM/WB by changing parameters only.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_slot.sv | 39 +++
 rtl/pipe_stage_buffer.sv | 137 +++++++++++++
 tb/tb_pipe_stage_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage registers: control-bundle bit positions,
// default field widths and the ID/EX data-word layout.
package pipe_pkg;

  localparam int unsigned CTRL_REGDST    = 0;
  localparam int unsigned CTRL_JUMP      = 1;
  localparam int unsigned CTRL_BRANCH    = 2;
  localparam int unsigned CTRL_MEMREAD   = 3;
  localparam int unsigned CTRL_MEMTOREG  = 4;
  localparam int unsigned CTRL_ALUOP_LSB = 5;
  localparam int unsigned CTRL_MEMWRITE  = 9;
  localparam int unsigned CTRL_ALUSRC    = 10;
  localparam int unsigned CTRL_REGWRITE  = 11;

  localparam int unsigned CTRL_W_DEFAULT = 12;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  localparam int unsigned W_NEXTPC = 0;
  localparam int unsigned W_RD1    = 1;
  localparam int unsigned W_RD2    = 2;
  localparam int unsigned W_SEXT   = 3;
  localparam int unsigned W_JDIR   = 4;

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the stage buffer: control field, opaque payload and a valid bit.
// Clear zeroes control and valid but leaves the payload untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned PAY_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              validNext,
  input  logic [CTRL_W-1:0] ctrlNext,
  input  logic [PAY_W-1:0]  payNext,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [PAY_W-1:0]  pay
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      pay   <= '0;
    end else begin
      valid <= clear ? 1'b0 : validNext;
      if (clear) begin
        ctrl <= '0;
      end else if (load) begin
        ctrl <= ctrlNext;
      end
      if (load && !clear) begin
        pay <= payNext;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register: valid/ready handshake over a main slot plus one skid slot,
// synchronous flush, occupancy report and a saturating stall counter.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W              = CTRL_W_DEFAULT,
  parameter int unsigned DATA_W              = DATA_W_DEFAULT,
  parameter int unsigned NDATA               = 5,
  parameter int unsigned ADDR_W              = ADDR_W_DEFAULT,
  parameter int unsigned STALL_CNT_W         = 16,
  parameter bit          ZERO_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [NDATA*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]       rt_i,
  input  logic [ADDR_W-1:0]       rd_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [NDATA*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]       rt_o,
  output logic [ADDR_W-1:0]       rd_o,
  input  logic                    flush,
  output logic [1:0]              occupancy,
  output logic [STALL_CNT_W-1:0]  stall_cnt,
  input  logic                    stall_cnt_clr
);

  localparam int unsigned DW    = NDATA * DATA_W;
  localparam int unsigned PAY_W = DW + 2 * ADDR_W;

  logic              mainValid, skidValid;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl, mainCtrlNext;
  logic [PAY_W-1:0]  mainPay, skidPay, mainPayNext, inPay;
  logic              mainLoad, skidLoad, mainFromSkid;
  logic              mainValidNext, skidValidNext;
  logic              accept, fire;
  logic [STALL_CNT_W-1:0] stallCntQ;

  assign in_ready = ~skidValid;
  assign accept   = in_valid & in_ready;
  assign fire     = mainValid & out_ready;
  assign inPay    = {rd_i, rt_i, data_i};

  always_comb begin
    mainLoad      = 1'b0;
    skidLoad      = 1'b0;
    mainFromSkid  = 1'b0;
    mainValidNext = mainValid;
    skidValidNext = skidValid;
    if (flush) begin
      mainValidNext = 1'b0;
      skidValidNext = 1'b0;
    end else if (!mainValid) begin
      mainLoad      = accept;
      mainValidNext = accept;
    end else if (fire) begin
      if (skidValid) begin
        mainLoad      = 1'b1;
        mainFromSkid  = 1'b1;
        skidValidNext = 1'b0;
      end else begin
        mainLoad      = accept;
        mainValidNext = accept;
      end
    end else begin
      // accept implies the skid is empty, so it is never overwritten
      skidLoad      = accept;
      skidValidNext = skidValid | accept;
    end
  end

  assign mainCtrlNext = mainFromSkid ? skidCtrl : ctrl_i;
  assign mainPayNext  = mainFromSkid ? skidPay : inPay;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .PAY_W  (PAY_W)
  ) uMain (
    .clk       (clk),
    .rst       (rst),
    .load      (mainLoad),
    .clear     (flush),
    .validNext (mainValidNext),
    .ctrlNext  (mainCtrlNext),
    .payNext   (mainPayNext),
    .valid     (mainValid),
    .ctrl      (mainCtrl),
    .pay       (mainPay)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .PAY_W  (PAY_W)
  ) uSkid (
    .clk       (clk),
    .rst       (rst),
    .load      (skidLoad),
    .clear     (flush),
    .validNext (skidValidNext),
    .ctrlNext  (ctrl_i),
    .payNext   (inPay),
    .valid     (skidValid),
    .ctrl      (skidCtrl),
    .pay       (skidPay)
  );

  assign out_valid = mainValid;
  assign data_o    = mainPay[DW-1:0];
  assign rt_o      = mainPay[DW +: ADDR_W];
  assign rd_o      = mainPay[DW + ADDR_W +: ADDR_W];
  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

  // Stale control left in an empty main slot must not reach the next stage
  if (ZERO_CTRL_ON_BUBBLE) begin : gen_ctrl_gate
    assign ctrl_o = mainCtrl & {CTRL_W{mainValid}};
  end else begin : gen_ctrl_pass
    assign ctrl_o = mainCtrl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntQ <= '0;
    end else if (stall_cnt_clr) begin
      stallCntQ <= '0;
    end else if (mainValid && !out_ready && !(&stallCntQ)) begin
      stallCntQ <= stallCntQ + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stallCntQ;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: a default-parameter instance and a wide-data,
// 4-bit-counter instance share handshake stimulus; a monitor checks every fired payload.
module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, out_ready, flush, clr;
  logic [11:0]  ctrl_in;
  logic [159:0] data0_in;
  logic [4:0]   rt0_in, rd0_in;
  logic [127:0] data1_in;
  logic [5:0]   rt1_in, rd1_in;

  logic         in_ready0, out_valid0;
  logic [11:0]  ctrl0_o;
  logic [159:0] data0_o;
  logic [4:0]   rt0_o, rd0_o;
  logic [1:0]   occ0;
  logic [15:0]  stall0;

  logic         in_ready1, out_valid1;
  logic [11:0]  ctrl1_o;
  logic [127:0] data1_o;
  logic [5:0]   rt1_o, rd1_o;
  logic [1:0]   occ1;
  logic [3:0]   stall1;

  pipe_stage_buffer uDut0 (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready0),
    .ctrl_i        (ctrl_in),
    .data_i        (data0_in),
    .rt_i          (rt0_in),
    .rd_i          (rd0_in),
    .out_valid     (out_valid0),
    .out_ready     (out_ready),
    .ctrl_o        (ctrl0_o),
    .data_o        (data0_o),
    .rt_o          (rt0_o),
    .rd_o          (rd0_o),
    .flush         (flush),
    .occupancy     (occ0),
    .stall_cnt     (stall0),
    .stall_cnt_clr (clr)
  );

  pipe_stage_buffer #(
    .DATA_W      (64),
    .NDATA       (2),
    .ADDR_W      (6),
    .STALL_CNT_W (4)
  ) uDut1 (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready1),
    .ctrl_i        (ctrl_in),
    .data_i        (data1_in),
    .rt_i          (rt1_in),
    .rd_i          (rd1_in),
    .out_valid     (out_valid1),
    .out_ready     (out_ready),
    .ctrl_o        (ctrl1_o),
    .data_o        (data1_o),
    .rt_o          (rt1_o),
    .rd_o          (rd1_o),
    .flush         (flush),
    .occupancy     (occ1),
    .stall_cnt     (stall1),
    .stall_cnt_clr (clr)
  );

  typedef struct {
    logic [11:0]  ctrl;
    logic [159:0] d0;
    logic [4:0]   rt0, rd0;
    logic [127:0] d1;
    logic [5:0]   rt1, rd1;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a payload derived from w; push it as expected unless it is meant to be flushed.
  task automatic send(input logic [11:0] c, input logic [31:0] w, input bit push);
    exp_t e;
    e.ctrl = c;
    e.d0   = {w + 32'd16, w + 32'd12, w + 32'd8, w + 32'd4, w};
    e.rt0  = w[6:2];
    e.rd0  = w[6:2] + 5'd1;
    e.d1   = {64'hDEADBEEF_CAFEF00D, 32'h0, w};
    e.rt1  = w[7:2];
    e.rd1  = ~w[7:2];
    ctrl_in  = e.ctrl;
    data0_in = e.d0;
    rt0_in   = e.rt0;
    rd0_in   = e.rd0;
    data1_in = e.d1;
    rt1_in   = e.rt1;
    rd1_in   = e.rd1;
    in_valid = 1'b1;
    if (push) begin
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected output: got ctrl %0h word0 %0h expected none", ctrl0_o,
                 data0_o[31:0]);
      end else begin
        m0 = q0.pop_front();
        chk("dut0 ctrl", ctrl0_o, m0.ctrl);
        chk("dut0 data", data0_o, m0.d0);
        chk("dut0 rt", rt0_o, m0.rt0);
        chk("dut0 rd", rd0_o, m0.rd0);
      end
    end
    if (!rst && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected output: got ctrl %0h word0 %0h expected none", ctrl1_o,
                 data1_o[63:0]);
      end else begin
        m1 = q1.pop_front();
        chk("dut1 ctrl", ctrl1_o, m1.ctrl);
        chk("dut1 data", data1_o, m1.d1);
        chk("dut1 rt", rt1_o, m1.rt1);
        chk("dut1 rd", rd1_o, m1.rd1);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr = 1'b0;
    ctrl_in = '0; data0_in = '0; rt0_in = '0; rd0_in = '0;
    data1_in = '0; rt1_in = '0; rd1_in = '0;

    #12;
    chk("reset in_ready", in_ready0, 1);
    chk("reset out_valid", out_valid0, 0);
    chk("reset occupancy", occ0, 0);
    chk("reset ctrl_o", ctrl0_o, 0);
    chk("reset stall_cnt", stall0, 0);
    chk("reset dut1 in_ready", in_ready1, 1);
    rst = 1'b0;
    tick;

    // Streaming at full throughput
    out_ready = 1'b1;
    send(12'h801, 32'h100, 1'b1); tick;
    chk("stream word0 a", data0_o[31:0], 32'h100);
    chk("stream occ a", occ0, 1);
    chk("stream in_ready a", in_ready0, 1);
    chk("stream dut1 word1", data1_o[127:64], 64'hDEADBEEF_CAFEF00D);
    send(12'h802, 32'h104, 1'b1); tick;
    chk("stream word0 b", data0_o[31:0], 32'h104);
    chk("stream occ b", occ0, 1);
    chk("stream in_ready b", in_ready0, 1);
    send(12'h204, 32'h108, 1'b1); tick;
    chk("stream word0 c", data0_o[31:0], 32'h108);
    chk("stream dut1 word0 c", data1_o[63:0], 64'h108);
    in_valid = 1'b0; tick;
    chk("stream drained valid", out_valid0, 0);
    chk("stream drained occ", occ0, 0);
    chk("bubble ctrl zeroed", ctrl0_o, 0);
    chk("bubble ctrl zeroed dut1", ctrl1_o, 0);

    // Backpressure into the skid slot
    out_ready = 1'b0; clr = 1'b1;
    send(12'h0A5, 32'h200, 1'b1); tick;
    clr = 1'b0;
    chk("bp occ 1", occ0, 1);
    chk("bp in_ready 1", in_ready0, 1);
    chk("bp stall 0", stall0, 0);
    send(12'h15A, 32'h204, 1'b1); tick;
    in_valid = 1'b0;
    chk("bp occ 2", occ0, 2);
    chk("bp in_ready 0", in_ready0, 0);
    chk("bp dut1 in_ready 0", in_ready1, 0);
    chk("bp stall 1", stall0, 1);
    chk("bp dut1 stall 1", stall1, 1);
    tick;
    chk("bp stall 2", stall0, 2);
    chk("bp occ held", occ0, 2);
    chk("bp head word0", data0_o[31:0], 32'h200);
    out_ready = 1'b1; tick;
    chk("bp release occ", occ0, 1);
    chk("bp release in_ready", in_ready0, 1);
    chk("bp second word0", data0_o[31:0], 32'h204);
    chk("bp stall held", stall0, 2);
    tick;
    chk("bp drained occ", occ0, 0);

    // Flush with both slots full and a simultaneous input
    out_ready = 1'b0;
    send(12'hFFF, 32'h300, 1'b1); tick;
    send(12'hFFF, 32'h304, 1'b1); tick;
    chk("flush pre occ", occ0, 2);
    send(12'hFFF, 32'h308, 1'b0);
    flush = 1'b1;
    q0.delete(); q1.delete();
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", out_valid0, 0);
    chk("flush ctrl_o", ctrl0_o, 0);
    chk("flush occ", occ0, 0);
    chk("flush in_ready", in_ready0, 1);
    chk("flush dut1 occ", occ1, 0);
    out_ready = 1'b1; tick; tick;
    chk("flush nothing emerges", out_valid0, 0);

    // Flush discards an input that would otherwise have been accepted
    out_ready = 1'b0;
    send(12'h801, 32'h400, 1'b1); tick;
    chk("flush2 pre occ", occ0, 1);
    send(12'hFFF, 32'h404, 1'b0);
    flush = 1'b1;
    q0.delete(); q1.delete();
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2 occ", occ0, 0);
    out_ready = 1'b1; tick;
    chk("flush2 nothing emerges", out_valid0, 0);
    send(12'h003, 32'h500, 1'b1); tick;
    chk("post flush word0", data0_o[31:0], 32'h500);
    in_valid = 1'b0; tick;

    // Stall counter saturation and clear
    out_ready = 1'b0; clr = 1'b1;
    send(12'h010, 32'h600, 1'b1); tick;
    clr = 1'b0; in_valid = 1'b0;
    repeat (20) tick;
    chk("stall 16b count", stall0, 20);
    chk("stall 4b saturate", stall1, 15);
    clr = 1'b1; tick;
    chk("stall clr dut0", stall0, 0);
    chk("stall clr dut1", stall1, 0);
    clr = 1'b0; tick;
    chk("stall after clr dut0", stall0, 1);
    chk("stall after clr dut1", stall1, 1);
    out_ready = 1'b1; tick;

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    send(12'h7FF, 32'h700, 1'b1); tick;
    send(12'h7FE, 32'h704, 1'b1); tick;
    in_valid = 1'b0;
    chk("arst pre occ", occ0, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst out_valid", out_valid0, 0);
    chk("arst occ", occ0, 0);
    chk("arst in_ready", in_ready0, 1);
    chk("arst ctrl_o", ctrl0_o, 0);
    chk("arst stall", stall0, 0);
    chk("arst data_o", data0_o, 0);
    chk("arst dut1 occ", occ1, 0);
    q0.delete(); q1.delete();
    #3 rst = 1'b0;
    tick;
    chk("arst idle after", out_valid0, 0);

    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
